// File: rtl/overlay_pkg.sv
// Shared types and helpers for the overlay upscaler: pixel formats, the
// default border colour and the BGR5 -> RGB8 expansion.
package overlay_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  typedef struct packed {
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } bgr5_t;

  localparam logic [23:0] DEFAULT_BORDER = 24'h303030;

  // Zero-fill the low bits so a full-scale channel maps to 8'hF8.
  function automatic rgb8_t bgr5_to_rgb8(input bgr5_t c);
    rgb8_t o;
    o.r = {c.r, 3'b000};
    o.g = {c.g, 3'b000};
    o.b = {c.b, 3'b000};
    return o;
  endfunction

endpackage

// File: rtl/dda_axis.sv
// One axis of the fractional upscaler: a saturating DDA that advances the
// source coordinate by SRC/DST of a pixel per step.
module dda_axis #(
  parameter  int SRC = 256,
  parameter  int DST = 960,
  localparam int CW  = (SRC > 1) ? $clog2(SRC) : 1,
  localparam int AW  = $clog2(DST) + 1
) (
  input  logic          clk_pixel,
  input  logic          resetn,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] coord
);

  localparam logic [AW-1:0] SRC_A = AW'(SRC);
  localparam logic [AW-1:0] DST_A = AW'(DST);
  localparam logic [CW-1:0] LAST  = CW'(SRC - 1);

  logic [AW-1:0] acc_reg;
  logic [AW-1:0] acc_sum;

  // acc < DST and SRC <= DST, so the sum always fits in AW bits.
  assign acc_sum = acc_reg + SRC_A;

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      acc_reg <= '0;
      coord   <= '0;
    end else if (clear) begin
      acc_reg <= '0;
      coord   <= '0;
    end else if (step) begin
      if (acc_sum >= DST_A) begin
        acc_reg <= acc_sum - DST_A;
        if (coord != LAST) coord <= coord + 1'b1;
      end else begin
        acc_reg <= acc_sum;
      end
    end
  end

endmodule

// File: rtl/overlay_scaler.sv
// Fractional upscaler from a small BGR5 framebuffer to the HDMI pixel stream,
// addressing the source ahead of cx so fetch latency is hidden.
module overlay_scaler
  import overlay_pkg::*;
#(
  parameter int          SRC_W     = 256,
  parameter int          SRC_H     = 224,
  parameter int          DST_W     = 960,
  parameter int          DST_H     = 720,
  parameter int          FRAME_W   = 1280,
  parameter int          FRAME_H   = 720,
  parameter int          TOTAL_W   = 1650,
  parameter int          TOTAL_H   = 750,
  parameter int          FETCH_LAT = 1,
  parameter logic [23:0] BORDER    = DEFAULT_BORDER
) (
  input  logic                       clk_pixel,
  input  logic                       resetn,
  input  logic [10:0]                cx,
  input  logic [9:0]                 cy,
  input  logic                       overlay_en,
  output logic [$clog2(SRC_W)-1:0]   src_x,
  output logic [$clog2(SRC_H)-1:0]   src_y,
  input  logic [14:0]                src_color,
  output logic [23:0]                rgb,
  output logic                       in_window
);

  localparam int XSTART = (FRAME_W - DST_W) / 2;
  localparam int YSTART = (FRAME_H - DST_H) / 2;
  localparam int LEAD   = FETCH_LAT + 1;
  // The address register adds one more cycle on top of LEAD.
  localparam int AHEAD  = LEAD + 1;

  localparam logic [11:0] XS    = 12'(XSTART);
  localparam logic [11:0] TW    = 12'(TOTAL_W);
  localparam logic [9:0]  YS    = 10'(YSTART);
  localparam logic [9:0]  YPRE  = 10'((YSTART + TOTAL_H - 1) % TOTAL_H);
  localparam logic [9:0]  YLAST = 10'(TOTAL_H - 1);

  if (XSTART < LEAD || FETCH_LAT < 0 || FETCH_LAT > 4 ||
      DST_W < SRC_W || DST_H < SRC_H || DST_W > FRAME_W || DST_H > FRAME_H) begin : g_param_check
    $error("overlay_scaler: illegal parameter set");
  end

  logic [11:0] cx_sum;
  logic        lead_wrap;
  logic [11:0] lead_x;
  logic [9:0]  lead_y;
  logic [12:0] x_off;
  logic [10:0] y_off;
  logic        x_win;
  logic        y_win;
  logic        line_lead;
  logic        x_clear;
  logic        x_step;
  logic        y_clear;
  logic        y_step;
  logic        win_now;

  // Column/row whose address is being computed this cycle.
  assign cx_sum    = {1'b0, cx} + 12'(AHEAD);
  assign lead_wrap = cx_sum >= TW;
  assign lead_x    = lead_wrap ? cx_sum - TW : cx_sum;
  assign lead_y    = !lead_wrap ? cy : ((cy == YLAST) ? 10'd0 : cy + 10'd1);

  // Offsets wrap to large values below the window start.
  assign x_off = {1'b0, lead_x} - {1'b0, XS};
  assign y_off = {1'b0, lead_y} - {1'b0, YS};
  assign x_win = x_off < 13'(DST_W);
  assign y_win = y_off < 11'(DST_H);

  assign line_lead = lead_x == XS;
  assign x_clear   = line_lead;
  assign x_step    = x_win && !line_lead;
  assign y_clear   = line_lead && (lead_y == YPRE);
  assign y_step    = line_lead && y_win && (lead_y != YS);
  assign win_now   = x_win && y_win && overlay_en;

  dda_axis #(.SRC(SRC_W), .DST(DST_W)) u_dda_x (
    .clk_pixel (clk_pixel),
    .resetn    (resetn),
    .clear     (x_clear),
    .step      (x_step),
    .coord     (src_x)
  );

  dda_axis #(.SRC(SRC_H), .DST(DST_H)) u_dda_y (
    .clk_pixel (clk_pixel),
    .resetn    (resetn),
    .clear     (y_clear),
    .step      (y_step),
    .coord     (src_y)
  );

  // Window/enable travel alongside the fetch so they meet src_color in step.
  logic win_pipe [FETCH_LAT+1];

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i <= FETCH_LAT; i++) win_pipe[i] <= 1'b0;
    end else begin
      for (int i = FETCH_LAT; i > 0; i--) win_pipe[i] <= win_pipe[i-1];
      win_pipe[0] <= win_now;
    end
  end

  rgb8_t conv;
  assign conv = bgr5_to_rgb8(bgr5_t'(src_color));

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      rgb       <= BORDER;
      in_window <= 1'b0;
    end else begin
      rgb       <= win_pipe[FETCH_LAT] ? conv : BORDER;
      in_window <= win_pipe[FETCH_LAT];
    end
  end

endmodule

// File: tb/tb_overlay_scaler.sv
// Bench for overlay_scaler: three instances (FETCH_LAT 1, FETCH_LAT 3,
// letterboxed DST_H=672) share one raster, checked against a pixel-mapping model.
module tb_overlay_scaler;

  localparam int XSTART = (1280 - 960) / 2;
  localparam int NLIT   = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic        overlay_en;

  logic [7:0]  sx_a, sy_a, sx_b, sy_b, sx_c, sy_c;
  logic [14:0] col_a = '0, col_b1 = '0, col_b2 = '0, col_b3 = '0, col_c = '0;
  logic [23:0] rgb_a, rgb_b, rgb_c;
  logic        win_a, win_b, win_c;

  overlay_scaler #(.FETCH_LAT(1)) u_a (
    .clk_pixel(clk), .resetn(resetn), .cx(cx), .cy(cy), .overlay_en(overlay_en),
    .src_x(sx_a), .src_y(sy_a), .src_color(col_a), .rgb(rgb_a), .in_window(win_a));

  overlay_scaler #(.FETCH_LAT(3)) u_b (
    .clk_pixel(clk), .resetn(resetn), .cx(cx), .cy(cy), .overlay_en(overlay_en),
    .src_x(sx_b), .src_y(sy_b), .src_color(col_b3), .rgb(rgb_b), .in_window(win_b));

  overlay_scaler #(.FETCH_LAT(1), .DST_H(672)) u_c (
    .clk_pixel(clk), .resetn(resetn), .cx(cx), .cy(cy), .overlay_en(overlay_en),
    .src_x(sx_c), .src_y(sy_c), .src_color(col_c), .rgb(rgb_c), .in_window(win_c));

  // Source image: colour = 31*(x + 1024*y) mod 2^15.
  function automatic logic [14:0] pix(input int x, input int y);
    return 15'(31 * (x + 1024 * y));
  endfunction

  // Memories: one register stage for FETCH_LAT=1, three for FETCH_LAT=3.
  always @(posedge clk) begin
    col_a  <= pix(int'(sx_a), int'(sy_a));
    col_b1 <= pix(int'(sx_b), int'(sy_b));
    col_b2 <= col_b1;
    col_b3 <= col_b2;
    col_c  <= pix(int'(sx_c), int'(sy_c));
  end

  // {in_window, rgb} that frame pixel (c, r) must show.
  function automatic logic [24:0] expect_px(input int c, input int r, input int dsth, input bit en);
    int ys, x, y;
    logic [14:0] p;
    ys = (720 - dsth) / 2;
    if (en && c >= XSTART && c < XSTART + 960 && r >= ys && r < ys + dsth) begin
      x = (c - XSTART) * 256 / 960;
      y = (r - ys) * 224 / dsth;
      p = pix(x, y);
      return {1'b1, p[4:0], 3'b000, p[9:5], 3'b000, p[14:10], 3'b000};
    end
    return {1'b0, 24'h303030};
  endfunction

  int total = 0;
  int bad = 0;
  int frame_idx = -1;
  bit check_en = 1'b0;
  int run_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h (frame %0d row %0d col %0d)",
               name, act, expv, frame_idx, cy, cx);
    end
  endtask

  typedef struct {
    int          inst;
    int          frame;
    int          row;
    int          col;
    logic [23:0] rgb;
    logic        win;
  } lit_t;

  lit_t lits [NLIT];
  bit   lit_hit [NLIT];
  bit   seen_a [256];
  bit   seen_c [256];

  // Per-cycle compare once the raster has been continuous long enough to flush the pipe.
  always @(negedge clk) begin
    if (check_en && run_len >= 6) begin
      check("px_a", 32'(expect_px(int'(cx), int'(cy), 720, overlay_en)) ^ 32'(0) ^ 32'({win_a, rgb_a}) ^ 32'(expect_px(int'(cx), int'(cy), 720, overlay_en)),
            32'(expect_px(int'(cx), int'(cy), 720, overlay_en)));
      check("px_b", 32'({win_b, rgb_b}), 32'(expect_px(int'(cx), int'(cy), 720, overlay_en)));
      check("px_c", 32'({win_c, rgb_c}), 32'(expect_px(int'(cx), int'(cy), 672, overlay_en)));
      for (int i = 0; i < NLIT; i++) begin
        if (lits[i].frame == frame_idx && lits[i].row == int'(cy) && lits[i].col == int'(cx)) begin
          lit_hit[i] = 1'b1;
          case (lits[i].inst)
            0:       check($sformatf("lit%0d_a", i), 32'({win_a, rgb_a}), 32'({lits[i].win, lits[i].rgb}));
            1:       check($sformatf("lit%0d_b", i), 32'({win_b, rgb_b}), 32'({lits[i].win, lits[i].rgb}));
            default: check($sformatf("lit%0d_c", i), 32'({win_c, rgb_c}), 32'({lits[i].win, lits[i].rgb}));
          endcase
        end
      end
      if (frame_idx == 0 && cx >= 11'd160 && cx <= 11'd169) begin
        seen_a[sy_a] = 1'b1;
        seen_c[sy_c] = 1'b1;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_rgb_a"}, 32'(rgb_a), 32'h303030);
    check({tag, "_win_a"}, 32'(win_a), 32'd0);
    check({tag, "_sx_a"},  32'(sx_a),  32'd0);
    check({tag, "_sy_a"},  32'(sy_a),  32'd0);
    check({tag, "_rgb_b"}, 32'(rgb_b), 32'h303030);
    check({tag, "_win_b"}, 32'(win_b), 32'd0);
    check({tag, "_sx_c"},  32'(sx_c),  32'd0);
    check({tag, "_sy_c"},  32'(sy_c),  32'd0);
  endtask

  task automatic drive_row(input int row, input int c0, input int c1, input bit en, input int rst_col);
    for (int c = c0; c <= c1; c++) begin
      @(posedge clk);
      #1;
      cx = 11'(c);
      cy = 10'(row);
      overlay_en = en;
      run_len = (c == c0) ? 0 : run_len + 1;
      if (c == rst_col) begin
        check_en = 1'b0;
        #2 resetn = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
      end
      if (c == rst_col + 3) resetn = 1'b1;
    end
  endtask

  // Short bursts around the lead point on every line; full active span on a few.
  task automatic run_frame(input int f, input bit en_gap, input int rst_row);
    bit en;
    frame_idx = f;
    for (int r = 0; r < 750; r++) begin
      en = !(en_gap && r >= 100 && r <= 199);
      if (r == rst_row)                       drive_row(r, 140, 1135, en, 500);
      else if (r == 0 || r == 300 || r == 700) drive_row(r, 140, 1135, en, -10);
      else                                     drive_row(r, 150, 169, en, -10);
    end
  endtask

  initial begin
    int cnt_a, cnt_c;
    lits[0]  = '{0, 0, 0,   160,  24'h000000, 1'b1};
    lits[1]  = '{0, 0, 0,   163,  24'h000000, 1'b1};
    lits[2]  = '{0, 0, 0,   164,  24'hF80000, 1'b1};
    lits[3]  = '{0, 0, 0,   1119, 24'h08B838, 1'b1};
    lits[4]  = '{0, 0, 0,   1120, 24'h303030, 1'b0};
    lits[5]  = '{0, 0, 3,   164,  24'hF80000, 1'b1};
    lits[6]  = '{0, 0, 4,   160,  24'h0000F8, 1'b1};
    lits[7]  = '{0, 0, 719, 160,  24'h000008, 1'b1};
    lits[8]  = '{1, 0, 0,   1119, 24'h08B838, 1'b1};
    lits[9]  = '{1, 0, 0,   1120, 24'h303030, 1'b0};
    lits[10] = '{2, 0, 23,  160,  24'h303030, 1'b0};
    lits[11] = '{2, 0, 24,  160,  24'h000000, 1'b1};
    lits[12] = '{2, 0, 696, 160,  24'h303030, 1'b0};
    lits[13] = '{2, 0, 695, 160,  24'h000008, 1'b1};
    lits[14] = '{0, 1, 150, 160,  24'h303030, 1'b0};
    lits[15] = '{0, 1, 200, 160,  24'h000010, 1'b1};
    lits[16] = '{0, 2, 300, 164,  24'hF80018, 1'b1};

    resetn = 1'b0;
    cx = '0;
    cy = '0;
    overlay_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("init");
    @(posedge clk);
    #1 resetn = 1'b1;

    check_en = 1'b1;
    run_frame(0, 1'b0, -1);
    run_frame(1, 1'b1, 300);
    check_en = 1'b1;
    run_frame(2, 1'b0, -1);
    check_en = 1'b0;
    @(negedge clk);

    cnt_a = 0;
    cnt_c = 0;
    for (int i = 0; i < 256; i++) begin
      if (seen_a[i]) cnt_a++;
      if (seen_c[i]) cnt_c++;
    end
    check("ydistinct_a", 32'(cnt_a), 32'd224);
    check("ydistinct_c", 32'(cnt_c), 32'd224);
    for (int i = 0; i < NLIT; i++) check($sformatf("lit%0d_reached", i), 32'(lit_hit[i]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
